// File: rtl/amiga_clk_pkg.sv
// rtl/amiga_clk_pkg.sv - shared types and constants for the Amiga clock-enable generator
package amiga_clk_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        RUN       = 2'd2
    } state_e;

    localparam logic [3:0] PH_CLK7      = 4'd15;
    localparam logic [3:0] PH_CLK7N     = 4'd7;
    localparam logic [1:0] PH28_MASK    = 2'd3;

    localparam logic [3:0] E_PERIOD     = 4'd10;
    localparam logic [3:0] E_HIGH_START = 4'd6;

endpackage

// File: rtl/amiga_clk_enable_gen_sync_2ff.sv
// rtl/amiga_clk_enable_gen_sync_2ff.sv - two-flop synchronizer with synchronous reset to 0
module sync_2ff (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/amiga_clk_enable_gen.sv
// rtl/amiga_clk_enable_gen.sv - master-clock enables, E-clock and sequenced reset from PLL lock
module amiga_clk_enable_gen
    import amiga_clk_pkg::*;
#(
    parameter int unsigned RESET_HOLD = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic pll_locked,
    output logic clk28_en,
    output logic clk7_en,
    output logic clk7n_en,
    output logic cck_en,
    output logic eclk,
    output logic eclk_rise,
    output logic sys_reset,
    output logic lock_lost
);

    localparam logic [15:0] HOLD_LAST = 16'(RESET_HOLD - 1);
    localparam logic [3:0]  E_LAST    = E_PERIOD - 4'd1;

    logic        lock_s;
    state_e      state_q, state_d;
    logic [3:0]  ph_q, ph_d;
    logic        cck_ph_q, cck_ph_d;
    logic [3:0]  e_cnt_q, e_cnt_d;
    logic [15:0] hold_q, hold_d;
    logic        run_d;
    logic        tick;

    logic clk28_en_q, clk7_en_q, clk7n_en_q, cck_en_q;
    logic eclk_q, eclk_rise_q, sys_reset_q, lock_lost_q;

    sync_2ff u_lock_sync (
        .clk_i (clk),
        .rst_i (rst),
        .d_i   (pll_locked),
        .q_o   (lock_s)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            WAIT_LOCK: if (lock_s) state_d = HOLD;
            HOLD: begin
                if (!lock_s)                state_d = WAIT_LOCK;
                else if (hold_q == HOLD_LAST) state_d = RUN;
            end
            RUN:       if (!lock_s) state_d = WAIT_LOCK;
            default:   state_d = WAIT_LOCK;
        endcase
    end

    // Counters restart from zero on the HOLD entry edge so the first clk7_en lands 16 cycles later;
    // enables are gated on the next state so a lock loss silences them on the same edge.
    always_comb begin
        run_d    = (state_d != WAIT_LOCK);
        tick     = run_d && (ph_q == PH_CLK7);
        ph_d     = 4'd0;
        cck_ph_d = 1'b0;
        e_cnt_d  = 4'd0;
        hold_d   = 16'd0;
        if (state_q != WAIT_LOCK) begin
            ph_d     = ph_q + 4'd1;
            cck_ph_d = cck_ph_q ^ tick;
            e_cnt_d  = e_cnt_q;
            if (tick) e_cnt_d = (e_cnt_q == E_LAST) ? 4'd0 : e_cnt_q + 4'd1;
        end
        if (state_q == HOLD) hold_d = hold_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= WAIT_LOCK;
            ph_q        <= 4'd0;
            cck_ph_q    <= 1'b0;
            e_cnt_q     <= 4'd0;
            hold_q      <= 16'd0;
            clk28_en_q  <= 1'b0;
            clk7_en_q   <= 1'b0;
            clk7n_en_q  <= 1'b0;
            cck_en_q    <= 1'b0;
            eclk_q      <= 1'b0;
            eclk_rise_q <= 1'b0;
            sys_reset_q <= 1'b1;
            lock_lost_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ph_q        <= ph_d;
            cck_ph_q    <= cck_ph_d;
            e_cnt_q     <= e_cnt_d;
            hold_q      <= hold_d;
            clk28_en_q  <= run_d && ((ph_q[1:0] & PH28_MASK) == PH28_MASK);
            clk7_en_q   <= tick;
            clk7n_en_q  <= run_d && (ph_q == PH_CLK7N);
            cck_en_q    <= tick && cck_ph_q;
            eclk_q      <= run_d && (e_cnt_d >= E_HIGH_START);
            eclk_rise_q <= tick && (e_cnt_d == E_HIGH_START);
            sys_reset_q <= (state_d != RUN);
            lock_lost_q <= lock_lost_q || ((state_q == RUN) && !lock_s);
        end
    end

    assign clk28_en  = clk28_en_q;
    assign clk7_en   = clk7_en_q;
    assign clk7n_en  = clk7n_en_q;
    assign cck_en    = cck_en_q;
    assign eclk      = eclk_q;
    assign eclk_rise = eclk_rise_q;
    assign sys_reset = sys_reset_q;
    assign lock_lost = lock_lost_q;

endmodule

// File: tb/tb_amiga_clk_enable_gen.sv
// tb/tb_amiga_clk_enable_gen.sv - self-checking bench with a timeline reference model
module tb_amiga_clk_enable_gen;

    localparam int RH = 16;

    logic clk = 1'b0;
    logic rst;
    logic pll_locked;
    logic clk28_en, clk7_en, clk7n_en, cck_en, eclk, eclk_rise, sys_reset, lock_lost;

    int total = 0;
    int bad   = 0;

    // Reference: state 0=wait,1=hold,2=run; m_d counts cycles since HOLD entry.
    int m_state = 0;
    int m_d     = 0;
    bit m_s1 = 0, m_s2 = 0, m_lost = 0;

    amiga_clk_enable_gen #(.RESET_HOLD(RH)) dut (
        .clk        (clk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .clk28_en   (clk28_en),
        .clk7_en    (clk7_en),
        .clk7n_en   (clk7n_en),
        .cck_en     (cck_en),
        .eclk       (eclk),
        .eclk_rise  (eclk_rise),
        .sys_reset  (sys_reset),
        .lock_lost  (lock_lost)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0b expected=%0b t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge();
        int nxt;
        if (rst) begin
            m_state = 0; m_d = 0; m_s1 = 0; m_s2 = 0; m_lost = 0;
        end else begin
            nxt = m_state;
            case (m_state)
                0: if (m_s2) nxt = 1;
                1: if (!m_s2) nxt = 0; else if (m_d == RH - 1) nxt = 2;
                default: if (!m_s2) nxt = 0;
            endcase
            if (m_state == 2 && !m_s2) m_lost = 1;
            m_d     = (m_state == 0) ? 0 : m_d + 1;
            m_state = nxt;
            m_s2    = m_s1;
            m_s1    = pll_locked;
        end
    endtask

    task automatic check_all();
        bit act, c7;
        int n;
        act = (m_state != 0);
        n   = m_d / 16;
        c7  = act && m_d > 0 && (m_d % 16 == 0);
        chk("clk28_en",  clk28_en,  act && m_d > 0 && (m_d % 4 == 0));
        chk("clk7_en",   clk7_en,   c7);
        chk("clk7n_en",  clk7n_en,  act && (m_d % 16 == 8));
        chk("cck_en",    cck_en,    c7 && (n % 2 == 0));
        chk("eclk",      eclk,      act && (n % 10 >= 6));
        chk("eclk_rise", eclk_rise, c7 && (n % 10 == 6));
        chk("sys_reset", sys_reset, m_state != 2);
        chk("lock_lost", lock_lost, m_lost);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic wait_run(input string tag, input int exp_cycles);
        int cnt = 0;
        do begin
            step();
            cnt++;
        end while (sys_reset && cnt < 60);
        chk_int(tag, cnt, exp_cycles);
        chk({tag, "_clk7"}, clk7_en, 1'b1);
    endtask

    initial begin
        int c28, c7, c7n, cck, rise, hi, lo;
        rst = 1'b1;
        pll_locked = 1'b0;
        step();
        step();
        rst = 1'b0;

        repeat (100) step();
        chk("idle_sys_reset", sys_reset, 1'b1);

        pll_locked = 1'b1;
        wait_run("lock_to_run", 3 + RH);

        c28 = 0; c7 = 0; c7n = 0; cck = 0; rise = 0; hi = 0; lo = 0;
        for (int i = 0; i < 160; i++) begin
            step();
            c28 += int'(clk28_en); c7 += int'(clk7_en); c7n += int'(clk7n_en);
            cck += int'(cck_en); rise += int'(eclk_rise);
            if (clk7_en) begin
                if (eclk) hi++; else lo++;
            end
        end
        chk_int("cnt_clk28", c28, 40);
        chk_int("cnt_clk7", c7, 10);
        chk_int("cnt_clk7n", c7n, 10);
        chk_int("cnt_cck", cck, 5);
        chk_int("cnt_rise", rise, 1);
        chk_int("eclk_high_ticks", hi, 4);
        chk_int("eclk_low_ticks", lo, 6);

        pll_locked = 1'b0;
        repeat (3) step();
        chk("loss_sys_reset", sys_reset, 1'b1);
        chk("loss_clk28", clk28_en, 1'b0);
        chk("loss_lost", lock_lost, 1'b1);

        pll_locked = 1'b1;
        wait_run("relock_to_run", 3 + RH);
        chk("relock_lost_sticky", lock_lost, 1'b1);

        repeat (20) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_lost", lock_lost, 1'b0);
        chk("rst_sys_reset", sys_reset, 1'b1);
        chk("rst_eclk", eclk, 1'b0);

        repeat (3 + 8) step();
        pll_locked = 1'b0;
        repeat (3) step();
        chk("hold_drop_lost", lock_lost, 1'b0);
        chk("hold_drop_sys_reset", sys_reset, 1'b1);
        pll_locked = 1'b1;
        wait_run("hold_drop_relock", 3 + RH);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 59) == 0) pll_locked = ~pll_locked;
            rst = ($urandom_range(0, 399) == 0);
            step();
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/amiga_clk_enable_gen.md
# amiga_clk_enable_gen

Consumes the PLL outputs in the Amiga core: runs on the 113.5 MHz master clock and the PLL `locked` flag. Produces phase-aligned single-cycle clock enables for the 28 MHz, 7 MHz (both phases), colour-clock and 68000 E-clock domains, plus the sequenced system reset. All downstream logic runs on one clock with these enables. This replaces direct use of the divided PLL clocks.

## Interface
Parameters:
- `RESET_HOLD`, 1024: master-clock cycles `sys_reset` stays high after lock is seen stable; range 4..65535.

Ports:
- `clk`  in  1  113.5 MHz master clock (PLL outclk_0).
- `rst`  in  1  reset, synchronous, active-high.
- `pll_locked`  in  1  PLL lock flag, asynchronous to `clk`.
- `clk28_en`  out  1  28 MHz enable: one-cycle pulse every 4 cycles.
- `clk7_en`  out  1  7 MHz rising-phase enable: one pulse every 16 cycles.
- `clk7n_en`  out  1  7 MHz falling-phase enable: pulse 8 cycles after `clk7_en`.
- `cck_en`  out  1  colour-clock enable: every second `clk7_en`.
- `eclk`  out  1  E-clock level, period 10 `clk7_en` ticks: 6 low, 4 high.
- `eclk_rise`  out  1  one-cycle pulse on the tick where `eclk` goes high.
- `sys_reset`  out  1  system reset to the core, active-high.
- `lock_lost`  out  1  sticky: lock dropped after RUN was reached; cleared only by `rst`.

## Operation
- `pll_locked` passes through a 2-FF synchronizer, giving `lock_s`.
- Phase counter `ph[3:0]` free-runs modulo 16.
  - `clk28_en` = (ph[1:0]==3).
  - `clk7_en` = (ph==15).
  - `clk7n_en` = (ph==7).
- `cck_ph` toggles on every `clk7_en`. `cck_en` = `clk7_en` & `cck_ph`.
- `e_cnt` (0..9) advances on `clk7_en` and wraps 9→0.
  - `eclk` is registered high when the next `e_cnt` value is in 6..9.
  - `eclk_rise` pulses on the `clk7_en` cycle where `e_cnt` goes 5→6.
- FSM states:
  - WAIT_LOCK (reset state): `sys_reset`=1; all enables forced 0; `ph`, `cck_ph`, `e_cnt` and the hold counter held at 0. Goes to HOLD when `lock_s`=1.
  - HOLD: enables run; `sys_reset`=1; hold counter increments. Goes to RUN when the counter reaches RESET_HOLD-1. Returns to WAIT_LOCK if `lock_s`=0.
  - RUN: `sys_reset`=0; enables run. Returns to WAIT_LOCK if `lock_s`=0, and sets `lock_lost` that same cycle.
- Lock loss in HOLD does not set `lock_lost`.
- Phase is deterministic: on every WAIT_LOCK→HOLD entry the first `clk7_en` occurs exactly 16 cycles later.

## Timing
- Reset values: `sys_reset`=1; `clk28_en`, `clk7_en`, `clk7n_en`, `cck_en`, `eclk`, `eclk_rise`, `lock_lost`=0; FSM=WAIT_LOCK; synchronizer=0.
- `rst` overrides everything, including mid-HOLD or mid-RUN.
- Lock to HOLD: `pll_locked` rising before edge N gives `lock_s`=1 after edge N+1, and state=HOLD after edge N+2.
- HOLD to RUN: `sys_reset` falls after exactly RESET_HOLD cycles in HOLD.
- Lock loss: `pll_locked` falling before edge N gives state=WAIT_LOCK, `sys_reset`=1 and enables 0 after edge N+2, a 3-cycle worst case.
- A lock glitch shorter than one `clk` period may be missed; this is acceptable.
- All outputs are registered, with no combinational path from input to output.
- Enable pulses are exactly one cycle wide and never overlap incorrectly:
  - `clk7_en` and `clk7n_en` never both assert.
  - `clk7_en` always coincides with a `clk28_en`.

## Structure
- Package `amiga_clk_pkg` holds:
  - FSM state enum (WAIT_LOCK, HOLD, RUN);
  - phase constants PH_CLK7=15, PH_CLK7N=7, PH28_MASK=3;
  - E-clock constants E_PERIOD=10, E_HIGH_START=6.
- One sub-module: `sync_2ff` (1-bit, synchronous reset to 0), instantiated for `pll_locked`.

## Test plan
- Default `RESET_HOLD`=16. Hold `pll_locked`=0 for 100 cycles → `sys_reset`=1 and all enables 0 throughout.
- Raise `pll_locked` at cycle 10 → HOLD entered by cycle 12; `sys_reset` falls at cycle 28; first `clk7_en` at cycle 28.
- In RUN, count over 160 cycles → `clk28_en`=40, `clk7_en`=10, `clk7n_en`=10, `cck_en`=5, one full `eclk` period (6 ticks low, 4 high), one `eclk_rise`.
- Drop `pll_locked` in RUN → within 3 cycles `sys_reset`=1, enables 0, `lock_lost`=1. Re-lock → `lock_lost` stays 1 and phase restarts at 0.
- Drop `pll_locked` at HOLD count 8 → back to WAIT_LOCK with `lock_lost`=0. Re-lock → full 16-cycle hold repeats.
- Assert `rst` for 1 cycle mid-RUN → all outputs at reset values next cycle, including `lock_lost`=0.
